// File: rtl/tmr_scrub_reg_if.sv
// tmr_scrub_reg_if: bus bundle for the TMR scrubbing register.
//   wr_i/data_i : write strobe and data
//   upset_i     : fault-injection XOR mask, [3N-1:2N]=A, [2N-1:N]=B, [N-1:0]=C
//   clr_i       : clears error counter and fail flag
//   vtr_o       : 2-of-3 voted value
//   warn_o      : copies disagree
//   scrub_o     : scrub write in progress
//   err_cnt_o   : saturating scrub count
//   fail_o      : sticky repeat-upset-in-guard flag
// The master modport drives the inputs; the slave modport is the register.
interface tmr_scrub_reg_if #(
   parameter int N     = 32,
   parameter int CNT_W = 16
);
   logic             wr_i;
   logic [N-1:0]     data_i;
   logic [3*N-1:0]   upset_i;
   logic             clr_i;
   logic [N-1:0]     vtr_o;
   logic             warn_o;
   logic             scrub_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic             fail_o;

   modport master (
      output wr_i, data_i, upset_i, clr_i,
      input  vtr_o, warn_o, scrub_o, err_cnt_o, fail_o
   );

   modport slave (
      input  wr_i, data_i, upset_i, clr_i,
      output vtr_o, warn_o, scrub_o, err_cnt_o, fail_o
   );
endinterface

// File: rtl/tmr_scrub_reg.sv
// tmr_scrub_reg: triple-modular-redundant register with automatic scrubbing.
// Three copies are voted bitwise; any disagreement latches the voted value and
// rewrites all copies one cycle later, then a guard window watches for a repeat
// upset, which raises the sticky fail flag.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : tmr_scrub_reg_if slave (write, upset mask, clear, vote/status out)
module tmr_scrub_reg #(
   parameter int           N         = 32,
   parameter int           CNT_W     = 16,
   parameter int           GUARD_CYC = 8,
   parameter logic [N-1:0] RST_VAL   = '0
) (
   input logic            clk_i,
   input logic            rst_i,
   tmr_scrub_reg_if.slave bus
);

   typedef enum logic [1:0] {RUN, SCRUB, GUARD} state_t;

   state_t           state, state_d;
   logic [7:0]       gcnt, gcnt_d;
   logic [N-1:0]     ca, cb, cc, ca_d, cb_d, cc_d;
   logic [N-1:0]     scrub_q, scrub_q_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             fail, fail_d;
   logic [N-1:0]     vtr;
   logic             warn;
   logic             inc;

   assign vtr  = (ca & cb) | (ca & cc) | (cb & cc);
   assign warn = (ca != cb) || (cb != cc);

   assign bus.vtr_o     = vtr;
   assign bus.warn_o    = warn;
   // Reset in the SCRUB cycle aborts the write, so no pulse is shown.
   assign bus.scrub_o   = (state == SCRUB) && !rst_i;
   assign bus.err_cnt_o = cnt;
   assign bus.fail_o    = fail;

   always_comb begin
      state_d   = state;
      gcnt_d    = gcnt;
      scrub_q_d = scrub_q;
      fail_d    = fail;
      cnt_d     = cnt;
      inc       = 1'b0;

      // Copy update: write beats scrub beats fault injection.
      if (bus.wr_i) begin
         ca_d = bus.data_i;
         cb_d = bus.data_i;
         cc_d = bus.data_i;
      end else if (state == SCRUB) begin
         ca_d = scrub_q;
         cb_d = scrub_q;
         cc_d = scrub_q;
      end else begin
         ca_d = ca ^ bus.upset_i[3*N-1:2*N];
         cb_d = cb ^ bus.upset_i[2*N-1:N];
         cc_d = cc ^ bus.upset_i[N-1:0];
      end

      case (state)
         RUN: begin
            // A concurrent write repairs the mismatch, so no scrub is needed.
            if (warn && !bus.wr_i) begin
               scrub_q_d = vtr;
               state_d   = SCRUB;
               inc       = 1'b1;
            end
         end
         SCRUB: begin
            state_d = GUARD;
            gcnt_d  = 8'(GUARD_CYC - 1);
         end
         GUARD: begin
            if (warn && !bus.wr_i) begin
               fail_d    = 1'b1;
               scrub_q_d = vtr;
               state_d   = SCRUB;
               inc       = 1'b1;
            end else if (gcnt == 8'd0) begin
               state_d = RUN;
            end else begin
               gcnt_d = gcnt - 8'd1;
            end
         end
         default: state_d = RUN;
      endcase

      if (inc && !(&cnt)) cnt_d = cnt + 1'b1;
      if (bus.clr_i) begin
         cnt_d  = '0;
         fail_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= RUN;
         gcnt    <= '0;
         ca      <= RST_VAL;
         cb      <= RST_VAL;
         cc      <= RST_VAL;
         scrub_q <= '0;
         cnt     <= '0;
         fail    <= 1'b0;
      end else begin
         state   <= state_d;
         gcnt    <= gcnt_d;
         ca      <= ca_d;
         cb      <= cb_d;
         cc      <= cc_d;
         scrub_q <= scrub_q_d;
         cnt     <= cnt_d;
         fail    <= fail_d;
      end
   end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// tb_tmr_scrub_reg: directed and random checks of tmr_scrub_reg against a
// behavioural model. Two instances share stimulus: a 16-bit counter one and a
// 2-bit counter one for saturation.
module tb_tmr_scrub_reg;
   localparam int          N    = 32;
   localparam int          G    = 8;
   localparam logic [31:0] RSTV = 32'h0000_C3A5;

   logic clk = 1'b0;
   logic rst;
   logic wr, clr;
   logic [N-1:0]   data;
   logic [3*N-1:0] upset;

   always #5 clk = ~clk;

   tmr_scrub_reg_if #(.N(N), .CNT_W(16)) b1 ();
   tmr_scrub_reg_if #(.N(N), .CNT_W(2))  b2 ();

   assign b1.wr_i = wr;  assign b1.data_i = data;  assign b1.upset_i = upset;  assign b1.clr_i = clr;
   assign b2.wr_i = wr;  assign b2.data_i = data;  assign b2.upset_i = upset;  assign b2.clr_i = clr;

   tmr_scrub_reg #(.N(N), .CNT_W(16), .GUARD_CYC(G), .RST_VAL(RSTV)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(b1));
   tmr_scrub_reg #(.N(N), .CNT_W(2), .GUARD_CYC(G), .RST_VAL(RSTV)) dut2 (
      .clk_i(clk), .rst_i(rst), .bus(b2));

   int ncmp = 0;
   int nerr = 0;

   // Behavioural model: copies as an array, a pending-scrub flag and a count
   // of guard cycles remaining.
   logic [N-1:0] m_cp [3];
   logic [N-1:0] m_sq;
   bit           m_pend;
   int           m_guard;
   int           m_cnt;
   bit           m_fail;

   function automatic logic [N-1:0] m_vote();
      logic [N-1:0] v;
      for (int b = 0; b < N; b++) begin
         int ones;
         ones = 0;
         for (int i = 0; i < 3; i++) ones += int'(m_cp[i][b]);
         v[b] = (ones >= 2);
      end
      return v;
   endfunction

   function automatic bit m_mism();
      return (m_cp[0] != m_cp[1]) || (m_cp[1] != m_cp[2]);
   endfunction

   task automatic m_step();
      logic [N-1:0] v;
      bit           mm;
      if (rst) begin
         for (int i = 0; i < 3; i++) m_cp[i] = RSTV;
         m_sq = '0; m_pend = 0; m_guard = 0; m_cnt = 0; m_fail = 0;
         return;
      end
      v  = m_vote();
      mm = m_mism();
      if (m_pend) begin
         for (int i = 0; i < 3; i++) m_cp[i] = wr ? data : m_sq;
         m_pend  = 0;
         m_guard = G;
      end else begin
         for (int i = 0; i < 3; i++) m_cp[i] = wr ? data : (m_cp[i] ^ upset[(2-i)*N +: N]);
         if (mm && !wr) begin
            m_pend = 1;
            m_sq   = v;
            m_cnt++;
            if (m_guard > 0) m_fail = 1;
            m_guard = 0;
         end else if (m_guard > 0) begin
            m_guard--;
         end
      end
      if (clr) begin
         m_cnt  = 0;
         m_fail = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("vtr",   64'(b1.vtr_o),     64'(m_vote()));
      chk("warn",  64'(b1.warn_o),    64'(m_mism()));
      chk("scrub", 64'(b1.scrub_o),   64'(m_pend && !rst));
      chk("cnt16", 64'(b1.err_cnt_o), 64'((m_cnt > 65535) ? 65535 : m_cnt));
      chk("fail",  64'(b1.fail_o),    64'(m_fail));
      chk("cnt2",  64'(b2.err_cnt_o), 64'((m_cnt > 3) ? 3 : m_cnt));
      chk("fail2", 64'(b2.fail_o),    64'(m_fail));
      chk("vtr2",  64'(b2.vtr_o),     64'(m_vote()));
   endtask

   task automatic tick(input logic w, input logic [N-1:0] d, input logic [3*N-1:0] u,
                       input logic c, input logic r);
      wr = w; data = d; upset = u; clr = c; rst = r;
      @(posedge clk);
      m_step();
      #1;
      chk_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, '0, '0, 0, 0);
   endtask

   function automatic logic [3*N-1:0] one_hot_up(input int cpy, input int bitpos);
      logic [3*N-1:0] u;
      u = '0;
      u[(2-cpy)*N + bitpos] = 1'b1;
      return u;
   endfunction

   initial begin
      wr = 0; clr = 0; rst = 1; data = '0; upset = '0;
      #2;
      // Reset state
      tick(0, '0, '0, 0, 1);
      tick(0, '0, '0, 0, 0);
      chk("rst_vtr",  64'(b1.vtr_o), 64'(RSTV));
      chk("rst_warn", 64'(b1.warn_o), 64'd0);
      // Write 0xFF
      tick(1, 32'h0000_00FF, '0, 0, 0);
      chk("wr_vtr", 64'(b1.vtr_o), 64'h0000_00FF);
      chk("wr_cnt", 64'(b1.err_cnt_o), 64'd0);
      // Single upset on copy A bit 12, then scrub
      tick(0, '0, one_hot_up(0, 12), 0, 0);
      chk("up_warn", 64'(b1.warn_o), 64'd1);
      chk("up_vtr",  64'(b1.vtr_o), 64'h0000_00FF);
      tick(0, '0, '0, 0, 0);
      chk("scrub_pulse", 64'(b1.scrub_o), 64'd1);
      tick(0, '0, '0, 0, 0);
      chk("scrub_done_warn", 64'(b1.warn_o), 64'd0);
      chk("scrub_done_cnt",  64'(b1.err_cnt_o), 64'd1);
      // Repeat upset inside the guard window
      idle(2);
      tick(0, '0, one_hot_up(1, 3), 0, 0);
      tick(0, '0, '0, 0, 0);
      chk("guard_fail", 64'(b1.fail_o), 64'd1);
      chk("guard_cnt",  64'(b1.err_cnt_o), 64'd2);
      tick(0, '0, '0, 1, 0);
      chk("clr_fail", 64'(b1.fail_o), 64'd0);
      chk("clr_cnt",  64'(b1.err_cnt_o), 64'd0);
      idle(G + 2);
      // Write coincident with upset on copy B
      tick(1, 32'h0000_1100, one_hot_up(1, 5), 0, 0);
      chk("wrup_vtr",  64'(b1.vtr_o), 64'h0000_1100);
      chk("wrup_warn", 64'(b1.warn_o), 64'd0);
      tick(0, '0, '0, 0, 0);
      chk("wrup_noscrub", 64'(b1.scrub_o), 64'd0);
      // Five spaced upsets: 2-bit counter saturates
      for (int k = 0; k < 5; k++) begin
         tick(0, '0, one_hot_up(k % 3, $urandom_range(0, N-1)), 0, 0);
         idle(G + 4);
      end
      chk("sat_cnt2",  64'(b2.err_cnt_o), 64'd3);
      chk("sat_cnt16", 64'(b1.err_cnt_o), 64'd5);
      // Two copies hit in the same bit: vote flips and is scrubbed in
      tick(0, '0, one_hot_up(0, 0) | one_hot_up(2, 0), 0, 0);
      chk("mis_vtr", 64'(b1.vtr_o), 64'h0000_1101);
      idle(G + 4);
      // Reset during the SCRUB cycle
      tick(0, '0, one_hot_up(2, 9), 0, 0);
      tick(0, '0, '0, 0, 0);
      rst = 1; #1;
      chk("rst_scrub_nopulse", 64'(b1.scrub_o), 64'd0);
      tick(0, '0, '0, 0, 1);
      chk("rst_scrub_vtr", 64'(b1.vtr_o), 64'(RSTV));
      chk("rst_scrub_cnt", 64'(b1.err_cnt_o), 64'd0);
      tick(0, '0, '0, 0, 0);
      chk("rst_scrub_after", 64'(b1.scrub_o), 64'd0);
      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int             sel;
         logic [3*N-1:0] u;
         logic           w, c, r;
         sel = $urandom_range(0, 99);
         u = '0; w = 0; c = 0; r = 0;
         if (sel < 6)       w = 1;
         else if (sel < 8)  c = 1;
         else if (sel < 9)  r = 1;
         else if (sel < 22) u = one_hot_up($urandom_range(0, 2), $urandom_range(0, N-1));
         else if (sel < 25) begin
            int bp;
            bp = $urandom_range(0, N-1);
            u = one_hot_up(0, bp) | one_hot_up($urandom_range(1, 2), bp);
         end else if (sel < 28) u = {$urandom(), $urandom(), $urandom()};
         if ($urandom_range(0, 9) == 0) u = u | one_hot_up($urandom_range(0, 2), $urandom_range(0, N-1));
         tick(w, $urandom(), u, c, r);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/tmr_scrub_reg.md
TMR_SCRUB_REG -- requirements
Module: tmr_scrub_reg

Interface
REQ-001 The block SHALL have parameter N, default 32: data width per copy.
REQ-002 The block SHALL have parameter CNT_W, default 16: error-counter width.
REQ-003 The block SHALL have parameter GUARD_CYC, default 8: guard window after a scrub, in cycles, range 1..255.
REQ-004 The block SHALL have parameter RST_VAL, default 0: N-bit reset value of all three copies.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port wr_i, input, 1 bit: write strobe.
REQ-008 The block SHALL have port data_i, input, N bits: write data.
REQ-009 The block SHALL have port upset_i, input, 3N bits: fault-injection XOR mask; bits [3N-1:2N] target copy A, [2N-1:N] copy B, [N-1:0] copy C.
REQ-010 The block SHALL have port clr_i, input, 1 bit: clears err_cnt_o and fail_o.
REQ-011 The block SHALL have port vtr_o, output, N bits: bitwise 2-of-3 majority of copies A, B, C.
REQ-012 The block SHALL have port warn_o, output, 1 bit: high when any copy differs from another.
REQ-013 The block SHALL have port scrub_o, output, 1 bit: one-cycle pulse while a scrub write occurs.
REQ-014 The block SHALL have port err_cnt_o, output, CNT_W bits: saturating count of scrubs started.
REQ-015 The block SHALL have port fail_o, output, 1 bit: sticky flag for a repeat upset inside the guard window.

Function
REQ-016 vtr_o and warn_o SHALL be combinational from the three copy registers, with zero latency after the register update.
REQ-017 The FSM SHALL have states RUN, SCRUB and GUARD, with a guard counter gcnt of 8 bits.
REQ-018 Copy-register update priority per cycle SHALL be: rst_i, then wr_i, then scrub, then upset_i.
REQ-019 When wr_i=1, all copies SHALL load data_i on that edge; upset_i is ignored that cycle.
REQ-020 In RUN with no write and no scrub, each copy SHALL load copy XOR its upset_i slice.
REQ-021 In RUN, when warn_o=1 and wr_i=0, the FSM SHALL latch vtr_o into scrub_q and go to SCRUB; err_cnt_o SHALL increment on the same edge.
REQ-022 In RUN, when warn_o=1 and wr_i=1, the write SHALL clear the mismatch, and the FSM SHALL stay in RUN with no increment.
REQ-023 In SCRUB, all copies SHALL load scrub_q (wr_i wins if asserted), scrub_o SHALL be 1, and the FSM SHALL go to GUARD with gcnt=GUARD_CYC-1.
REQ-024 In GUARD, the block SHALL decrement gcnt each cycle, go to RUN when gcnt=0, and apply upset_i as in RUN.
REQ-025 In GUARD, when warn_o=1 and wr_i=0, the FSM SHALL set fail_o, latch scrub_q, increment err_cnt_o and go to SCRUB.
REQ-026 err_cnt_o SHALL saturate at all-ones and never wrap.
REQ-027 When clr_i=1, err_cnt_o and fail_o SHALL be zeroed on that edge; clr_i wins over a simultaneous increment or fail set.
REQ-028 The scrub sequence SHALL be: detect (edge k), scrub_o=1 in cycle k+1, copies equal after edge k+1, warn_o=0 in cycle k+2.
REQ-029 The same upset_i bit position applied to two copies SHALL flip vtr_o for that bit; the block SHALL scrub the flipped value without detecting the miscorrection.

Reset
REQ-030 On rst_i=1 at a clock edge, the block SHALL set all copies=RST_VAL, state=RUN, gcnt=0, scrub_q=0, err_cnt_o=0 and fail_o=0.
REQ-031 After reset, outputs SHALL read vtr_o=RST_VAL, warn_o=0 and scrub_o=0.
REQ-032 Reset asserted mid-SCRUB or mid-GUARD SHALL abort the sequence with no scrub write, leaving state=RUN.
REQ-033 Reset SHALL take priority over wr_i, clr_i and upset_i.

Verification
REQ-034 Reset, then wr_i with data_i=32'h000000FF -> next cycle vtr_o=32'h000000FF, warn_o=0, err_cnt_o=0.
REQ-035 From copies at 32'h000000FF, one-cycle upset_i with copy A mask=32'h00001000 -> warn_o=1, vtr_o=32'h000000FF; next cycle scrub_o=1; after that warn_o=0, A=32'h000000FF, err_cnt_o=1.
REQ-036 Second single-copy upset 3 cycles after scrub_o, with GUARD_CYC=8 -> fail_o=1, err_cnt_o=2; clr_i -> both 0.
REQ-037 Upset on copy B in the same cycle as wr_i with data_i=32'h1100 -> copies=32'h1100, warn_o=0, no scrub_o.
REQ-038 With CNT_W=2, five spaced single-copy upsets -> err_cnt_o holds 2'b11.
REQ-039 rst_i asserted during the SCRUB cycle -> no scrub_o pulse, copies=RST_VAL, counters 0.
